// File: rtl/cram_frame_loader.sv
// Configuration-RAM write/clear/readback sequencer for a ROWS x COLS logic-tile CRAM array.
// Keeps a shadow copy of every written row and drives it onto the tile's cbit bus.
module cram_frame_loader #(
  parameter int ROWS       = 16,
  parameter int COLS       = 4,
  parameter int WL_PULSE   = 2,
  parameter int CLR_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     prog,
  input  logic                     cmd_clear,
  input  logic                     cmd_read,
  input  logic [COLS-1:0]          frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [ROWS-1:0]          wl,
  output logic [ROWS-1:0]          pgate,
  output logic [ROWS-1:0]          cram_rst_b,
  output logic [COLS-1:0]          bl_drv,
  output logic                     bl_oe,
  input  logic [COLS-1:0]          bl_in,
  output logic [COLS-1:0]          rd_data,
  output logic                     rd_mismatch,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ROWS*COLS-1:0]     cbit,
  output logic [$clog2(ROWS)-1:0]  row_ptr,
  output logic                     load_done,
  output logic                     read_done,
  output logic                     abort
);

  localparam int RW   = $clog2(ROWS);
  localparam int MAXC = (WL_PULSE > CLR_CYCLES) ? WL_PULSE : CLR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [ROWS-1:0] ROW0 = ROWS'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, WR, RD, RDOUT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [ROWS*COLS-1:0]   shadow;
  logic [RW-1:0]          row_next;
  logic                   last_row;
  logic                   last_pulse;

  assign cbit        = shadow;
  assign last_row    = (row_ptr == RW'(ROWS - 1));
  assign row_next    = last_row ? '0 : row_ptr + 1'b1;
  assign last_pulse  = (cnt == CW'(WL_PULSE - 1));
  assign frame_ready = prog && (state == IDLE) && !cmd_clear && !cmd_read;

  // Dropping prog outside IDLE overrides everything and returns the array to a quiet state.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      row_ptr     <= '0;
      wl          <= '0;
      pgate       <= '0;
      cram_rst_b  <= '1;
      bl_drv      <= '0;
      bl_oe       <= 1'b0;
      rd_data     <= '0;
      rd_mismatch <= 1'b0;
      rd_valid    <= 1'b0;
      load_done   <= 1'b0;
      read_done   <= 1'b0;
      abort       <= 1'b0;
    end else begin
      load_done <= 1'b0;
      read_done <= 1'b0;
      abort     <= 1'b0;
      if (state != IDLE && !prog) begin
        state      <= IDLE;
        cnt        <= '0;
        row_ptr    <= '0;
        wl         <= '0;
        pgate      <= '0;
        cram_rst_b <= '1;
        bl_drv     <= '0;
        bl_oe      <= 1'b0;
        rd_valid   <= 1'b0;
        abort      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (prog) begin
              if (cmd_clear) begin
                state      <= CLEAR;
                cnt        <= '0;
                shadow     <= '0;
                row_ptr    <= '0;
                cram_rst_b <= '0;
              end else if (cmd_read) begin
                state   <= RD;
                cnt     <= '0;
                row_ptr <= '0;
                wl      <= ROW0;
              end else if (frame_valid) begin
                state  <= WR;
                cnt    <= '0;
                wl     <= ROW0 << row_ptr;
                pgate  <= ROW0 << row_ptr;
                bl_drv <= frame_data;
                bl_oe  <= 1'b1;
              end
            end
          end
          CLEAR: begin
            if (cnt == CW'(CLR_CYCLES - 1)) begin
              state      <= IDLE;
              cnt        <= '0;
              cram_rst_b <= '1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          // The shadow row is committed only at the end of a complete pulse.
          WR: begin
            if (last_pulse) begin
              shadow[row_ptr*COLS +: COLS] <= bl_drv;
              state     <= IDLE;
              cnt       <= '0;
              wl        <= '0;
              pgate     <= '0;
              bl_drv    <= '0;
              bl_oe     <= 1'b0;
              row_ptr   <= row_next;
              load_done <= last_row;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD: begin
            if (last_pulse) begin
              rd_data     <= bl_in;
              rd_mismatch <= (bl_in != shadow[row_ptr*COLS +: COLS]);
              rd_valid    <= 1'b1;
              wl          <= '0;
              cnt         <= '0;
              state       <= RDOUT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RDOUT: begin
            if (rd_ready) begin
              rd_valid <= 1'b0;
              cnt      <= '0;
              if (last_row) begin
                state     <= IDLE;
                row_ptr   <= '0;
                read_done <= 1'b1;
              end else begin
                state   <= RD;
                row_ptr <= row_next;
                wl      <= ROW0 << row_next;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
